// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - pixel FIFO handshake between upstream pixel source and the VGA timing controller
interface vga_timing_ctrl_if #(
  parameter int RGB_W = 16
);
  logic             pix_valid_i;
  logic [RGB_W-1:0] pix_data_i;
  logic             pix_ready_o;

  modport master (output pix_valid_i, output pix_data_i, input pix_ready_o);
  modport slave  (input pix_valid_i, input pix_data_i, output pix_ready_o);
endinterface

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA H/V phase sequencer with sync, data-enable and pixel handshake
// Optional sticky underrun detection under `define VGA_TIMING_UNDERRUN_EN.
module vga_timing_ctrl #(
  parameter int CNT_W = 12,
  parameter int RGB_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             en_i,
  input  logic [CNT_W-1:0] hvsize_i,
  input  logic [CNT_W-1:0] hfpsize_i,
  input  logic [CNT_W-1:0] hsnsize_i,
  input  logic [CNT_W-1:0] hbpsize_i,
  input  logic [CNT_W-1:0] vvsize_i,
  input  logic [CNT_W-1:0] vfpsize_i,
  input  logic [CNT_W-1:0] vsnsize_i,
  input  logic [CNT_W-1:0] vbpsize_i,
  vga_timing_ctrl_if.slave pix,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [RGB_W-1:0] rgb_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             frame_start_o,
  output logic             line_end_o,
  output logic             underrun_o
);

  typedef enum logic [2:0] {H_IDLE, H_VIS, H_FP, H_SYNC, H_BP} h_state_t;
  typedef enum logic [2:0] {V_IDLE, V_VIS, V_FP, V_SYNC, V_BP} v_state_t;

  h_state_t h_state, h_state_n;
  v_state_t v_state, v_state_n;
  logic [CNT_W-1:0] h_cnt, h_cnt_n, v_cnt, v_cnt_n;
  logic [CNT_W-1:0] hv_s, hfp_s, hsn_s, hbp_s, vfp_s, vsn_s, vbp_s;
  logic [CNT_W-1:0] x_q, y_q;
  logic line_end, frame_wrap, start, de;

  // Phase down-counters load size-1; a zero size behaves as one.
  function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] s);
    return (s == '0) ? '0 : s - CNT_W'(1);
  endfunction

  assign start      = (h_state == H_IDLE) && en_i;
  assign line_end   = (h_state == H_BP) && (h_cnt == '0);
  assign frame_wrap = line_end && (v_state == V_BP) && (v_cnt == '0);
  assign de         = (h_state == H_VIS) && (v_state == V_VIS);

  always_comb begin
    h_state_n = h_state;
    h_cnt_n   = h_cnt;
    v_state_n = v_state;
    v_cnt_n   = v_cnt;
    if (!en_i) begin
      h_state_n = H_IDLE;
      h_cnt_n   = '0;
      v_state_n = V_IDLE;
      v_cnt_n   = '0;
    end else begin
      case (h_state)
        H_IDLE: begin h_state_n = H_VIS; h_cnt_n = m1(hvsize_i); end
        H_VIS:  if (h_cnt == '0) begin h_state_n = H_FP;   h_cnt_n = m1(hfp_s); end
                else h_cnt_n = h_cnt - CNT_W'(1);
        H_FP:   if (h_cnt == '0) begin h_state_n = H_SYNC; h_cnt_n = m1(hsn_s); end
                else h_cnt_n = h_cnt - CNT_W'(1);
        H_SYNC: if (h_cnt == '0) begin h_state_n = H_BP;   h_cnt_n = m1(hbp_s); end
                else h_cnt_n = h_cnt - CNT_W'(1);
        H_BP:   if (h_cnt == '0) begin
                  h_state_n = H_VIS;
                  h_cnt_n   = m1(frame_wrap ? hvsize_i : hv_s);
                end else h_cnt_n = h_cnt - CNT_W'(1);
        default: begin h_state_n = H_IDLE; h_cnt_n = '0; end
      endcase
      // vvsize is only consumed at frame start, straight from the input.
      case (v_state)
        V_IDLE: begin v_state_n = V_VIS; v_cnt_n = m1(vvsize_i); end
        V_VIS:  if (line_end) begin
                  if (v_cnt == '0) begin v_state_n = V_FP; v_cnt_n = m1(vfp_s); end
                  else v_cnt_n = v_cnt - CNT_W'(1);
                end
        V_FP:   if (line_end) begin
                  if (v_cnt == '0) begin v_state_n = V_SYNC; v_cnt_n = m1(vsn_s); end
                  else v_cnt_n = v_cnt - CNT_W'(1);
                end
        V_SYNC: if (line_end) begin
                  if (v_cnt == '0) begin v_state_n = V_BP; v_cnt_n = m1(vbp_s); end
                  else v_cnt_n = v_cnt - CNT_W'(1);
                end
        V_BP:   if (line_end) begin
                  if (v_cnt == '0) begin v_state_n = V_VIS; v_cnt_n = m1(vvsize_i); end
                  else v_cnt_n = v_cnt - CNT_W'(1);
                end
        default: begin v_state_n = V_IDLE; v_cnt_n = '0; end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      h_state <= H_IDLE;
      v_state <= V_IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      hv_s    <= '0; hfp_s <= '0; hsn_s <= '0; hbp_s <= '0;
      vfp_s   <= '0; vsn_s <= '0; vbp_s <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      h_state <= h_state_n;
      v_state <= v_state_n;
      h_cnt   <= h_cnt_n;
      v_cnt   <= v_cnt_n;
      if (en_i && (start || frame_wrap)) begin
        hv_s  <= hvsize_i; hfp_s <= hfpsize_i; hsn_s <= hsnsize_i; hbp_s <= hbpsize_i;
        vfp_s <= vfpsize_i; vsn_s <= vsnsize_i; vbp_s <= vbpsize_i;
      end
      if (!en_i || start || line_end)
        x_q <= '0;
      else if (de && (h_cnt != '0))
        x_q <= x_q + CNT_W'(1);
      if (!en_i || start || frame_wrap)
        y_q <= '0;
      else if (line_end && (v_state == V_VIS) && (v_cnt != '0))
        y_q <= y_q + CNT_W'(1);
    end
  end

  assign hsync_o       = (h_state != H_SYNC);
  assign vsync_o       = (v_state != V_SYNC);
  assign de_o          = de;
  assign pix.pix_ready_o = de;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = de && (x_q == '0) && (y_q == '0);
  assign line_end_o    = line_end;

`ifdef VGA_TIMING_UNDERRUN_EN
  logic en_q, underrun_q;

  // Cleared by reset or by a fresh enable; a starved visible cycle sets it.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      en_q <= en_i;
      if (en_i && !en_q)
        underrun_q <= 1'b0;
      else if (de && !pix.pix_valid_i)
        underrun_q <= 1'b1;
    end
  end

  assign underrun_o = underrun_q;
  assign rgb_o      = (de && pix.pix_valid_i) ? pix.pix_data_i : '0;
`else
  assign underrun_o = 1'b0;
  assign rgb_o      = de ? pix.pix_data_i : '0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;
  localparam int CNT_W = 12;
  localparam int RGB_W = 16;

  logic             pclk = 1'b0;
  logic             presetn;
  logic             en_i;
  logic [CNT_W-1:0] hvsize_i, hfpsize_i, hsnsize_i, hbpsize_i;
  logic [CNT_W-1:0] vvsize_i, vfpsize_i, vsnsize_i, vbpsize_i;
  logic             hsync_o, vsync_o, de_o, frame_start_o, line_end_o, underrun_o;
  logic [RGB_W-1:0] rgb_o;
  logic [CNT_W-1:0] x_o, y_o;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_ctrl_if #(.RGB_W(RGB_W)) pif ();

  vga_timing_ctrl #(.CNT_W(CNT_W), .RGB_W(RGB_W)) dut (
    .pclk(pclk), .presetn(presetn), .en_i(en_i),
    .hvsize_i(hvsize_i), .hfpsize_i(hfpsize_i), .hsnsize_i(hsnsize_i), .hbpsize_i(hbpsize_i),
    .vvsize_i(vvsize_i), .vfpsize_i(vfpsize_i), .vsnsize_i(vsnsize_i), .vbpsize_i(vbpsize_i),
    .pix(pif.slave),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .rgb_o(rgb_o),
    .x_o(x_o), .y_o(y_o), .frame_start_o(frame_start_o), .line_end_o(line_end_o),
    .underrun_o(underrun_o)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, then present a new random pixel away from the edge.
  task automatic step();
    @(posedge pclk);
    #1;
    pif.pix_data_i = RGB_W'($urandom);
    #1;
  endtask

  task automatic check_idle();
    check_eq("idle_hsync", 32'(hsync_o), 32'd1);
    check_eq("idle_vsync", 32'(vsync_o), 32'd1);
    check_eq("idle_de", 32'(de_o), 32'd0);
    check_eq("idle_ready", 32'(pif.pix_ready_o), 32'd0);
    check_eq("idle_rgb", 32'(rgb_o), 32'd0);
    check_eq("idle_x", 32'(x_o), 32'd0);
    check_eq("idle_y", 32'(y_o), 32'd0);
    check_eq("idle_fs", 32'(frame_start_o), 32'd0);
    check_eq("idle_le", 32'(line_end_o), 32'd0);
  endtask

  initial begin
    int c, l, hvf, hv_in;
    logic exp_de;
    presetn = 1'b0;
    en_i    = 1'b0;
    hvsize_i = 12'd4; hfpsize_i = 12'd1; hsnsize_i = 12'd2; hbpsize_i = 12'd1;
    vvsize_i = 12'd3; vfpsize_i = 12'd1; vsnsize_i = 12'd1; vbpsize_i = 12'd1;
    pif.pix_valid_i = 1'b1;
    pif.pix_data_i  = '0;
    repeat (3) step();
    check_idle();
    check_eq("rst_underrun", 32'(underrun_o), 32'd0);

    @(posedge pclk);
    #1;
    presetn = 1'b1;
    en_i    = 1'b1;

    // Frames A,B at hv=4 (48 cycles); hv=6 written in B line 1 lands in C; hfp=0 written in C lands in D.
    c = 0; l = 0; hvf = 4; hv_in = 4;
    for (int t = 0; t < 216; t++) begin
      step();
      exp_de = (c < hvf) && (l < 3);
      check_eq("de", 32'(de_o), 32'(exp_de));
      check_eq("ready", 32'(pif.pix_ready_o), 32'(exp_de));
      check_eq("hsync", 32'(hsync_o), (c == hvf + 1 || c == hvf + 2) ? 32'd0 : 32'd1);
      check_eq("vsync", 32'(vsync_o), (l == 4) ? 32'd0 : 32'd1);
      check_eq("line_end", 32'(line_end_o), 32'(c == hvf + 3));
      check_eq("frame_start", 32'(frame_start_o), 32'(c == 0 && l == 0));
      check_eq("rgb", 32'(rgb_o), exp_de ? 32'(pif.pix_data_i) : 32'd0);
      check_eq("underrun", 32'(underrun_o), 32'd0);
      if (exp_de) begin
        check_eq("x", 32'(x_o), 32'(c));
        check_eq("y", 32'(y_o), 32'(l));
      end
      if (t == 56) begin hvsize_i = 12'd6; hv_in = 6; end
      if (t == 96) hfpsize_i = 12'd0;
      c++;
      if (c == hvf + 4) begin
        c = 0;
        l++;
        if (l == 6) begin l = 0; hvf = hv_in; end
      end
    end

    // Disable mid-line at x=2, then re-enable for a fresh frame.
    step();
    check_eq("e_fs0", 32'(frame_start_o), 32'd1);
    step();
    step();
    check_eq("e_x2", 32'(x_o), 32'd2);
    check_eq("e_de2", 32'(de_o), 32'd1);
    en_i = 1'b0;
    step();
    check_idle();
    en_i = 1'b1;
    step();
    check_eq("re_fs", 32'(frame_start_o), 32'd1);
    check_eq("re_de", 32'(de_o), 32'd1);
    check_eq("re_x", 32'(x_o), 32'd0);
    check_eq("re_y", 32'(y_o), 32'd0);
    check_eq("re_hsync", 32'(hsync_o), 32'd1);

`ifdef VGA_TIMING_UNDERRUN_EN
    step();
    pif.pix_valid_i = 1'b0;
    #1;
    check_eq("ur_x1", 32'(x_o), 32'd1);
    check_eq("ur_rgb0", 32'(rgb_o), 32'd0);
    check_eq("ur_not_yet", 32'(underrun_o), 32'd0);
    pif.pix_valid_i = 1'b1;
    step();
    check_eq("ur_set", 32'(underrun_o), 32'd1);
    check_eq("ur_rgb", 32'(rgb_o), 32'(pif.pix_data_i));
    step();
    step();
    check_eq("ur_sticky", 32'(underrun_o), 32'd1);
    en_i = 1'b0;
    step();
    check_eq("ur_idle_hold", 32'(underrun_o), 32'd1);
    en_i = 1'b1;
    step();
    check_eq("ur_clear", 32'(underrun_o), 32'd0);
    check_eq("ur_fs", 32'(frame_start_o), 32'd1);
`else
    step();
    pif.pix_valid_i = 1'b0;
    #1;
    check_eq("nu_x1", 32'(x_o), 32'd1);
    check_eq("nu_rgb", 32'(rgb_o), 32'(pif.pix_data_i));
    pif.pix_valid_i = 1'b1;
    step();
    check_eq("nu_underrun", 32'(underrun_o), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA scan-out from the programmed timing registers: CTRL enable, H/V visible, front-porch, sync and back-porch sizes.
- Runs horizontal and vertical phase state machines and drives hsync, vsync and data-enable.
- Issues a pixel-ready handshake to the upstream pixel FIFO and passes RGB through.
- Sits between the APB4 register block and the vga_if pins; the future framebuffer DMA consumes frame_start_o.

Parameters:
- CNT_W, 12, width of every size input and of the x/y counters.
- RGB_W, 16, pixel data width.

Ports:
- pclk  in  1  Clock.
- presetn  in  1  Reset. Synchronous, active-low.
- en_i  in  1  Scan-out enable (CTRL bit 0).
- hvsize_i, hfpsize_i, hsnsize_i, hbpsize_i  in  CNT_W each  Horizontal phase lengths, in pixels.
- vvsize_i, vfpsize_i, vsnsize_i, vbpsize_i  in  CNT_W each  Vertical phase lengths, in lines.
- pix_valid_i  in  1  Upstream FIFO holds a pixel.
- pix_data_i  in  RGB_W  Upstream pixel.
- pix_ready_o  out  1  Pixel consumed this cycle.
- hsync_o  out  1  Horizontal sync, active-low.
- vsync_o  out  1  Vertical sync, active-low.
- de_o  out  1  Display enable.
- rgb_o  out  RGB_W  Pixel to pins.
- x_o  out  CNT_W  Visible column.
- y_o  out  CNT_W  Visible row.
- frame_start_o  out  1  One-cycle pulse on the first pixel of a frame.
- line_end_o  out  1  One-cycle pulse on the last cycle of each line.
- underrun_o  out  1  Sticky underrun flag (see Optional Feature).

Behaviour:
- All state is in flops; outputs decode registered state with no added latency.
- Reset values: hsync_o=1, vsync_o=1, de_o=0, pix_ready_o=0, rgb_o=0, x_o=0, y_o=0, frame_start_o=0, line_end_o=0, underrun_o=0. H and V FSMs in IDLE.
- H FSM: IDLE -> H_VIS -> H_FP -> H_SYNC -> H_BP -> H_VIS.
  - Each phase lasts its size value in cycles, counted by a down-counter loaded on phase entry.
  - A size of 0 is treated as 1.
- V FSM: IDLE -> V_VIS -> V_FP -> V_SYNC -> V_BP -> V_VIS.
  - Advances only on line_end, i.e. the last H_BP cycle. Each phase lasts its size value in lines; 0 is treated as 1.
- Start:
  - A clock edge with en_i=1 in IDLE latches all eight sizes into shadow registers.
  - Both FSMs enter VIS; that cycle shows x_o=0, y_o=0, de_o=1, frame_start_o=1.
- Shadow registers reload only at the start of each frame (last cycle of V_BP together with line_end). Size writes made mid-frame take effect on the next frame.
- hsync_o=0 exactly while H_SYNC. vsync_o=0 for whole lines while V_SYNC, aligned to line start.
- de_o = H_VIS and V_VIS. pix_ready_o = de_o. rgb_o = pix_data_i when de_o, else 0.
- x_o:
  - Increments each de cycle within a line; range 0..hvsize-1.
  - Resets to 0 on H_VIS entry; holds its last value outside H_VIS.
- y_o:
  - Increments on each line_end inside V_VIS; range 0..vvsize-1.
  - Resets to 0 at frame start.
- Line and frame totals:
  - Horizontal total = hv+hfp+hsn+hbp cycles. Vertical total = sum of the V sizes in lines.
  - Sums are implicit in the FSM, so no overflow is possible.
- en_i deasserted, sampled on any edge:
  - The next cycle returns to IDLE with all outputs at reset values except underrun_o.
  - Re-enabling starts a fresh frame.
- Reset mid-frame behaves identically to the en_i deassert case and also clears underrun_o.

Optional Feature:
- Macro: VGA_TIMING_UNDERRUN_EN.
- Defined:
  - Any cycle with de_o=1 and pix_valid_i=0 is an underrun.
  - On an underrun, rgb_o outputs 0 and underrun_o sets the next cycle.
  - underrun_o stays set until reset or until a rising edge of en_i.
- Not defined: underrun_o is tied to 0 and no detection logic exists. rgb_o still follows the de_o rule above.

Test Plan:
- Timing: hv=4, hfp=1, hsn=2, hbp=1, vv=3, vfp=1, vsn=1, vbp=1, en_i=1 -> 8-cycle lines, 48-cycle frame.
  - hsync_o low at line cycles 5-6; de_o high at cycles 0-3 of lines 0-2.
  - vsync_o low for all of line 4; frame_start_o pulses every 48 cycles.
- Counters and pulses under the same timing -> x_o sequence 0,1,2,3 each visible line; y_o 0,1,2; line_end_o on line cycle 7 of every line.
- Shadow reload: write hvsize_i=6 during frame 1 line 1 -> frame 1 lines stay 8 cycles; frame 2 lines are 10 cycles with 6 de cycles.
- Zero size: hfpsize_i=0 -> front porch lasts 1 cycle; line total = hv+1+hsn+hbp.
- Disable mid-line: drop en_i at x_o=2 -> next cycle de_o=0, hsync_o=1, vsync_o=1. Re-enable -> frame_start_o with x_o=0, y_o=0.
- Underrun (macro defined): pix_valid_i=0 on the second visible pixel -> rgb_o=0 that cycle, underrun_o=1 from the next cycle until en_i is re-asserted. With macro undefined, underrun_o stays 0.
